// File: rtl/wfifo_pkg.sv
// Shared HyperBus write-path definitions: legal bus widths, RWDS mask polarity
// and the serialized halfword beat seen by the PHY.
package wfifo_pkg;

    localparam int DW_LEGAL_16 = 16;
    localparam int DW_LEGAL_32 = 32;
    localparam int DW_LEGAL_64 = 64;

    // RWDS level that masks a byte during a write transaction
    localparam logic MASK_ACTIVE = 1'b1;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  mask;
        logic        last;
    } hw_beat_t;

    function automatic logic dw_is_legal(input int dw);
        return (dw == DW_LEGAL_16) || (dw == DW_LEGAL_32) || (dw == DW_LEGAL_64);
    endfunction

endpackage

// File: rtl/wfifo_ram.sv
// Register-array storage for wfifo entries: synchronous write, asynchronous read.
module wfifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Entry write; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wfifo.sv
// HyperBus write-data buffer: stores bus words with strobes and serializes each
// into 16-bit halfwords (halfword 0 first) with RWDS byte mask and burst-last flag.
module wfifo
    import wfifo_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        fifo_clk,
    input  logic                        fifo_arst,
    input  logic [DATA_BUS_WIDTH-1:0]   fifo_wr_din,
    input  logic [DATA_BUS_WIDTH/8-1:0] fifo_wr_strb,
    input  logic                        fifo_wr_last,
    input  logic                        fifo_wr_ena,
    output logic                        fifo_wr_full,
    output logic [15:0]                 fifo_rd_dout,
    output logic [1:0]                  fifo_rd_mask,
    output logic                        fifo_rd_last,
    input  logic                        fifo_rd_en,
    output logic                        fifo_rd_empty
);

    localparam int NHW  = DATA_BUS_WIDTH / 16;
    localparam int SW   = DATA_BUS_WIDTH / 8;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int HW_W = (NHW > 1) ? $clog2(NHW) : 1;
    localparam int EW   = DATA_BUS_WIDTH + SW + 1;

    generate
        if (!dw_is_legal(DATA_BUS_WIDTH)) begin : g_bad_dw
            $error("wfifo: DATA_BUS_WIDTH must be 16, 32 or 64");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("wfifo: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [HW_W-1:0]           r_hw_idx;
    logic                      r_empty;
    logic                      r_full;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_hw_last;
    logic                      w_free;
    logic [CW-1:0]             w_count_nxt;
    logic [EW-1:0]             w_entry;
    logic [DATA_BUS_WIDTH-1:0] w_din;
    logic [SW-1:0]             w_strb;
    logic [1:0]                w_strb_hw;
    hw_beat_t                  w_beat;

    assign w_push    = fifo_wr_ena & ~r_full;
    assign w_pop     = fifo_rd_en & ~r_empty;
    assign w_hw_last = (r_hw_idx == HW_W'(NHW - 1));
    assign w_free    = w_pop & w_hw_last;

    wfifo_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .i_clk   (fifo_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({fifo_wr_din, fifo_wr_strb, fifo_wr_last}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_entry)
    );

    // Occupancy update; a push paired with an entry-freeing pop cancels out
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_free})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, serializer index, occupancy and registered flags
    always_ff @(posedge fifo_clk or posedge fifo_arst) begin
        if (fifo_arst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_hw_idx <= {HW_W{1'b0}};
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                if (w_hw_last) begin
                    r_hw_idx <= {HW_W{1'b0}};
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end else begin
                    r_hw_idx <= r_hw_idx + HW_W'(1);
                end
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == {CW{1'b0}});
            r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
        end
    end

    assign w_din     = w_entry[EW-1 -: DATA_BUS_WIDTH];
    assign w_strb    = w_entry[SW:1];
    assign w_strb_hw = w_strb[2 * int'(r_hw_idx) +: 2];

    // Head halfword, forced to an idle, fully masked beat while empty
    always_comb begin
        if (r_empty) begin
            w_beat.data = 16'h0000;
            w_beat.mask = {2{MASK_ACTIVE}};
            w_beat.last = 1'b0;
        end else begin
            w_beat.data = w_din[16 * int'(r_hw_idx) +: 16];
            w_beat.mask = ~w_strb_hw ^ {2{~MASK_ACTIVE}};
            w_beat.last = w_entry[0] & w_hw_last;
        end
    end

    assign fifo_rd_dout  = w_beat.data;
    assign fifo_rd_mask  = w_beat.mask;
    assign fifo_rd_last  = w_beat.last;
    assign fifo_rd_empty = r_empty;
    assign fifo_wr_full  = r_full;

endmodule

// File: doc/wfifo.md
# wfifo

Single-clock write-data buffer on the memory-write path of the HyperBus controller. It accepts DATA_BUS_WIDTH-wide words with byte strobes from the bus-side write channel and stores them in a shallow FIFO. It then serializes each word into 16-bit halfwords, each with a 2-bit byte mask and a burst-last flag, for the PHY that drives DQ/RWDS during a write transaction.

## Interface
- DATA_BUS_WIDTH, 32, bus-side word width; legal values 16, 32, 64; any other value is an elaboration error.
- FIFO_DEPTH, 16, number of bus-side word entries; power of two, at least 2.
- fifo_clk  in  1  single clock for both sides.
- fifo_arst  in  1  reset, asynchronous and active-high.
- fifo_wr_din  in  DATA_BUS_WIDTH  bus-side write data.
- fifo_wr_strb  in  DATA_BUS_WIDTH/8  byte enables; 1 means the byte is written.
- fifo_wr_last  in  1  word is the final word of the burst.
- fifo_wr_ena  in  1  push request.
- fifo_wr_full  out  1  no free entry.
- fifo_rd_dout  out  16  current halfword.
- fifo_rd_mask  out  2  byte mask for the current halfword; bit i = ~strb of byte i; 1 means masked (RWDS high).
- fifo_rd_last  out  1  current halfword is the final halfword of the burst.
- fifo_rd_en  in  1  pop the current halfword.
- fifo_rd_empty  out  1  no halfword available.

## Operation
- NHW = DATA_BUS_WIDTH/16 halfwords per entry. Halfword k of an entry = din[16k+15:16k] with mask ~strb[2k+1:2k]. Emission order is k = 0 first (little-endian), the exact inverse of the read-path packing.
- Storage is a circular array with wr_ptr, rd_ptr (log2 FIFO_DEPTH bits, natural wrap-around) and count (log2 FIFO_DEPTH + 1 bits).
- hw_idx (log2 NHW bits, zero width when NHW = 1) selects the halfword within the head entry.
- Push: fifo_wr_ena & ~fifo_wr_full stores {din, strb, last} at wr_ptr, then wr_ptr+1.
- Push while full is dropped with no state change, even if a pop occurs in the same cycle.
- Pop: fifo_rd_en & ~fifo_rd_empty.
  - If hw_idx < NHW-1: hw_idx+1.
  - Else: hw_idx = 0, rd_ptr+1, entry freed.
- fifo_rd_en while empty is ignored.
- Simultaneous push and entry-freeing pop leaves count unchanged.
- fifo_rd_empty = (count == 0). fifo_wr_full = (count == FIFO_DEPTH).
- fifo_rd_last = stored last & (hw_idx == NHW-1). It is never asserted on earlier halfwords.
- While empty, the outputs are forced to: dout = 16'h0000, mask = 2'b11, last = 0.
- Reset values: count, ptrs, hw_idx = 0; fifo_rd_empty = 1; fifo_wr_full = 0; dout = 0; mask = 2'b11; last = 0. Stored data is not reset.
- Reset mid-burst discards all entries and any partially serialized word; the first word after reset begins at halfword 0.

## Timing
- Read side is first-word-fall-through. A push on edge N makes fifo_rd_empty fall after edge N, so the halfword is poppable at edge N+1.
- Output halfword, mask and last are combinational from storage at rd_ptr/hw_idx. They are valid whenever fifo_rd_empty = 0.
- fifo_wr_full and fifo_rd_empty are decoded from count, which is registered. There is no combinational path from fifo_wr_ena or fifo_rd_en to any output.
- Sustained throughput: one halfword per cycle on the read side; one word per NHW cycles drains the array.

## Structure
- Shared controller package/include holds the legal DATA_BUS_WIDTH values and the mask-polarity constant (1 = masked), shared with the PHY write path.
- NHW and the pointer widths are local constants.
- One sub-module: wfifo_ram, a FIFO_DEPTH × (DATA_BUS_WIDTH + DATA_BUS_WIDTH/8 + 1) register array with synchronous write and asynchronous read.
- Pointer, count and serializer logic stay in wfifo.

## Test plan
- Reset, then idle: empty = 1, full = 0, dout = 0000, mask = 11, last = 0; fifo_rd_en pulses change nothing.
- DW = 32: push 32'hBBBBAAAA, strb 4'b1101, last = 1; pop twice → AAAA/mask 10/last 0, then BBBB/mask 00/last 1, then empty.
- DW = 64, depth 4: push 5 words without popping → full after the 4th, 5th dropped; drain 16 halfwords in order, then empty.
- Full with simultaneous push and freeing pop: push rejected, count becomes depth−1, full deasserts.
- Continuous push and pop across pointer wrap-around (3 × depth words): output sequence equals input sequence, no gaps when rd_en is held.
- Assert fifo_arst mid-word (hw_idx = 1 of 4): empty = 1 immediately; the next pushed word emits its halfword 0 first.
